// File: rtl/tx_rate_ctrl_if.sv
// Configuration, burst-control and status signals of the TX symbol-rate divider.
interface tx_rate_ctrl_if #(
  parameter int CW = 8,
  parameter int LW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_half;
  logic [LW-1:0] cfg_len;
  logic          start;
  logic          stop;
  logic          clk_out;
  logic          sym_tick;
  logic          busy;
  logic          done;
  logic [LW-1:0] tick_cnt;

  modport master (
    output cfg_valid, cfg_half, cfg_len, start, stop,
    input  cfg_ready, clk_out, sym_tick, busy, done, tick_cnt
  );

  modport slave (
    input  cfg_valid, cfg_half, cfg_len, start, stop,
    output cfg_ready, clk_out, sym_tick, busy, done, tick_cnt
  );
endinterface

// File: rtl/tx_rate_ctrl.sv
// Burst-oriented clock divider: emits a 50% duty clk_out of 2*(half+1) cycles and
// one sym_tick per rising edge, for cfg_len ticks or until stopped.
//
// state  | meaning
// IDLE   | waiting for start; configuration accepted here
// RUN    | dividing and counting symbol ticks
// FINISH | completing the current high phase, no further ticks
module tx_rate_ctrl #(
  parameter int CW       = 8,
  parameter int LW       = 16,
  parameter int DEF_HALF = 127
) (
  input  logic           clk,
  input  logic           rst,
  tx_rate_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] half_reg, half_n;
  logic [LW-1:0] len_reg, len_n;
  logic [LW-1:0] tick_q, tick_n, tick_inc;
  logic          clk_out_q, clk_out_n;
  logic          sym_q, sym_n;
  logic          done_q, done_n;
  logic          wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      half_reg  <= CW'(DEF_HALF);
      len_reg   <= '0;
      tick_q    <= '0;
      clk_out_q <= 1'b0;
      sym_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      half_reg  <= half_n;
      len_reg   <= len_n;
      tick_q    <= tick_n;
      clk_out_q <= clk_out_n;
      sym_q     <= sym_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    half_n    = half_reg;
    len_n     = len_reg;
    tick_n    = tick_q;
    clk_out_n = clk_out_q;
    sym_n     = 1'b0;
    done_n    = 1'b0;
    wrap      = (cnt == half_reg);
    tick_inc  = tick_q + LW'(1);

    case (state)
      S_IDLE: begin
        if (bus.cfg_valid) begin
          half_n = bus.cfg_half;
          len_n  = bus.cfg_len;
        end
        if (bus.start) begin
          state_n   = S_RUN;
          cnt_n     = '0;
          clk_out_n = 1'b0;
          tick_n    = '0;
        end
      end
      S_RUN: begin
        if (wrap) begin
          cnt_n     = '0;
          clk_out_n = ~clk_out_q;
          if (!clk_out_q) begin
            sym_n  = 1'b1;
            tick_n = tick_inc;
            if ((len_reg != '0) && (tick_inc == len_reg)) state_n = S_FINISH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
        if (bus.stop) state_n = S_FINISH;
      end
      S_FINISH: begin
        // Leaving only once low means a 0->1 toggle can never happen here.
        if (!clk_out_q) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          cnt_n   = '0;
        end else if (wrap) begin
          cnt_n     = '0;
          clk_out_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.cfg_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.clk_out   = clk_out_q;
  assign bus.sym_tick  = sym_q;
  assign bus.done      = done_q;
  assign bus.tick_cnt  = tick_q;
endmodule

// File: tb/tb_tx_rate_ctrl.sv
// Directed bench for tx_rate_ctrl with hand-computed cycle-exact expectations.
module tb_tx_rate_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ticks;

  tx_rate_ctrl_if #(.CW(8), .LW(16)) bus ();

  tx_rate_ctrl #(.CW(8), .LW(16), .DEF_HALF(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic cv, input logic [7:0] h, input logic [15:0] l);
    bus.cfg_valid = cv;
    bus.cfg_half  = h;
    bus.cfg_len   = l;
    bus.start     = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = '0;
    bus.cfg_len   = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    #12 rst = 1'b1;
    step();

    // reset state
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clk", bus.clk_out, 0);
    chk("rst_tick", bus.tick_cnt, 0);
    chk("rst_done", bus.done, 0);

    // default divide-by-256, continuous
    kick(1'b0, 8'd0, 16'd0);
    chk("t1_busy", bus.busy, 1);
    chk("t1_ready", bus.cfg_ready, 0);
    repeat (127) step();
    chk("t1_clk127", bus.clk_out, 0);
    step();
    chk("t1_clk128", bus.clk_out, 1);
    chk("t1_sym128", bus.sym_tick, 1);
    chk("t1_cnt128", bus.tick_cnt, 1);
    repeat (128) step();
    chk("t1_clk256", bus.clk_out, 0);
    chk("t1_sym256", bus.sym_tick, 0);
    repeat (128) step();
    chk("t1_sym384", bus.sym_tick, 1);
    chk("t1_cnt384", bus.tick_cnt, 2);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    repeat (126) step();
    chk("t1_clk511", bus.clk_out, 1);
    step();
    chk("t1_clk512", bus.clk_out, 0);
    chk("t1_done512", bus.done, 0);
    step();
    chk("t1_done513", bus.done, 1);
    chk("t1_busy513", bus.busy, 0);
    chk("t1_cnt513", bus.tick_cnt, 2);

    // half=1, len=3 with same-cycle cfg
    kick(1'b1, 8'd1, 16'd3);
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("t2_sym%0d", k), bus.sym_tick, (k == 2 || k == 6 || k == 10) ? 1 : 0);
      chk($sformatf("t2_clk%0d", k), bus.clk_out,
          ((k >= 2 && k < 4) || (k >= 6 && k < 8) || (k >= 10 && k < 12)) ? 1 : 0);
      chk($sformatf("t2_done%0d", k), bus.done, (k == 13) ? 1 : 0);
      chk($sformatf("t2_busy%0d", k), bus.busy, (k < 13) ? 1 : 0);
    end
    chk("t2_cnt", bus.tick_cnt, 3);

    // half=3 continuous, stop while high
    kick(1'b1, 8'd3, 16'd0);
    repeat (4) step();
    chk("t3_sym4", bus.sym_tick, 1);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("t3_clk5", bus.clk_out, 1);
    repeat (2) step();
    chk("t3_clk7", bus.clk_out, 1);
    step();
    chk("t3_clk8", bus.clk_out, 0);
    chk("t3_done8", bus.done, 0);
    step();
    chk("t3_done9", bus.done, 1);
    chk("t3_cnt9", bus.tick_cnt, 1);
    step();
    chk("t3_done10", bus.done, 0);

    // cfg offered during RUN is ignored
    kick(1'b1, 8'd1, 16'd0);
    bus.cfg_valid = 1'b1; bus.cfg_half = 8'd9; bus.cfg_len = 16'd5;
    chk("t4_ready", bus.cfg_ready, 0);
    step();
    bus.cfg_valid = 1'b0;
    step();
    chk("t4_sym2", bus.sym_tick, 1);
    repeat (4) step();
    chk("t4_sym6", bus.sym_tick, 1);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    step();
    chk("t4_clk8", bus.clk_out, 0);
    step();
    chk("t4_done9", bus.done, 1);
    kick(1'b1, 8'd2, 16'd1);
    repeat (2) step();
    chk("t4b_sym2", bus.sym_tick, 0);
    step();
    chk("t4b_sym3", bus.sym_tick, 1);
    repeat (3) step();
    chk("t4b_clk6", bus.clk_out, 0);
    step();
    chk("t4b_done7", bus.done, 1);
    chk("t4b_cnt", bus.tick_cnt, 1);

    // divide-by-2, len=4
    kick(1'b1, 8'd0, 16'd4);
    ticks = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.sym_tick) ticks++;
      if (k <= 8) chk($sformatf("t5_clk%0d", k), bus.clk_out, k[0]);
      chk($sformatf("t5_done%0d", k), bus.done, (k == 9) ? 1 : 0);
    end
    chk("t5_ticks", ticks, 4);
    chk("t5_cnt", bus.tick_cnt, 4);

    // stop on the terminal tick, start in FINISH ignored
    kick(1'b1, 8'd1, 16'd2);
    repeat (5) step();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk("t6_sym6", bus.sym_tick, 1);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    chk("t6_clk8", bus.clk_out, 0);
    step();
    chk("t6_done9", bus.done, 1);
    chk("t6_cnt", bus.tick_cnt, 2);
    step();
    chk("t6_idle", bus.busy, 0);

    // async reset mid-burst
    kick(1'b1, 8'd3, 16'd0);
    repeat (5) step();
    chk("t7_pre_clk", bus.clk_out, 1);
    #3 rst = 1'b0;
    #1;
    chk("t7_clk", bus.clk_out, 0);
    chk("t7_busy", bus.busy, 0);
    chk("t7_cnt", bus.tick_cnt, 0);
    chk("t7_ready", bus.cfg_ready, 1);
    chk("t7_done", bus.done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t7_nodone%0d", k), bus.done, 0);
      chk($sformatf("t7_rdy%0d", k), bus.cfg_ready, 1);
    end
    kick(1'b0, 8'd0, 16'd0);
    repeat (127) step();
    chk("t7_clk127", bus.clk_out, 0);
    step();
    chk("t7_sym128", bus.sym_tick, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tx_rate_ctrl.md
TX_RATE_CTRL -- requirements
Module: tx_rate_ctrl

Interface
REQ-001 SHALL have parameter CW, default 8, meaning width of the half-period count.
REQ-002 SHALL have parameter LW, default 16, meaning width of the burst length and tick counter.
REQ-003 SHALL have parameter DEF_HALF, default 127, meaning the half-period value after reset (divide-by-256).
REQ-004 SHALL have port clk  input  1  system clock, all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  configuration offer.
REQ-007 SHALL have port cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid.
REQ-008 SHALL have port cfg_half  input  CW  half-period count; divide ratio = 2*(cfg_half+1).
REQ-009 SHALL have port cfg_len  input  LW  symbol ticks per burst; 0 = continuous.
REQ-010 SHALL have port start  input  1  single-cycle request to begin a burst.
REQ-011 SHALL have port stop  input  1  single-cycle request to end a burst early.
REQ-012 SHALL have port clk_out  output  1  registered divided clock, 50% duty.
REQ-013 SHALL have port sym_tick  output  1  one-cycle pulse coincident with each 0->1 of clk_out.
REQ-014 SHALL have port busy  output  1  high in RUN and FINISH.
REQ-015 SHALL have port done  output  1  one-cycle pulse on return to IDLE from FINISH.
REQ-016 SHALL have port tick_cnt  output  LW  sym_tick count in the current/last burst.

Function
REQ-017 SHALL implement states IDLE, RUN, FINISH; cfg_ready SHALL be 1 exactly when state is IDLE.
REQ-018 SHALL load half_reg/len_reg from cfg_half/cfg_len on cfg_valid&cfg_ready; cfg_valid outside IDLE SHALL be ignored.
REQ-019 IDLE->RUN on start; the same-cycle cfg handshake SHALL take effect for that burst; on entry cnt=0, clk_out=0, tick_cnt=0.
REQ-020 In RUN/FINISH, cnt SHALL increment each cycle; when cnt==half_reg, cnt SHALL clear and clk_out SHALL toggle.
REQ-021 First clk_out 0->1 SHALL occur half_reg+1 cycles after the start edge; period SHALL be 2*(half_reg+1) cycles.
REQ-022 Each 0->1 toggle SHALL assert sym_tick for that cycle and increment tick_cnt (wraps modulo 2^LW when len_reg==0).
REQ-023 RUN->FINISH when len_reg!=0 and the tick making tick_cnt==len_reg occurs, or when stop is sampled high.
REQ-024 FINISH SHALL keep dividing until clk_out is 0 (completing the high phase); if clk_out is already 0, leave next cycle.
REQ-025 FINISH->IDLE SHALL pulse done for one cycle, hold clk_out=0, clear cnt, retain tick_cnt.
REQ-026 FINISH SHALL never produce a sym_tick; a toggle that would go 0->1 in FINISH SHALL be suppressed.
REQ-027 start outside IDLE and stop outside RUN SHALL be ignored; stop coinciding with the terminal tick SHALL give the same result as the terminal tick alone.
REQ-028 cfg_half=0 SHALL give divide-by-2 (toggle every cycle) with correct ticks.

Reset
REQ-029 rst low SHALL immediately force state IDLE, clk_out=0, sym_tick=0, busy=0, done=0, tick_cnt=0, cnt=0, half_reg=DEF_HALF, len_reg=0, independent of clk.
REQ-030 Reset mid-burst SHALL abort without done pulse; after release the block SHALL be in IDLE with default configuration.

Verification
REQ-031 Reset, then start without cfg -> clk_out rises 128 cycles after start, period 256, continuous ticks, busy=1.
REQ-032 cfg_half=1, cfg_len=3 with start same cycle -> ticks at start+2, +6, +10; clk_out falls at +12; done at +13; tick_cnt=3.
REQ-033 cfg_half=3, len 0, stop at start+5 (clk_out high) -> clk_out falls at +8, done next cycle, tick_cnt=1.
REQ-034 cfg_valid with cfg_half=9 during RUN -> cfg_ready=0, period unchanged; new cfg accepted only after done.
REQ-035 cfg_half=0, cfg_len=4 -> clk_out toggles every cycle, exactly 4 sym_tick pulses, then done.
REQ-036 rst pulsed low mid-burst between edges -> outputs zero asynchronously, no done, cfg_ready=1 after release.
